frame_receiver: RTL and testbench

Receive-side frame parser for the team's UART link. Consumes the byte stream from the UART receiver (one `rx_valid` pulse per byte), hunts for the 13-byte frame header, checks length, function code, inverted checksum and tail, and latches the 8 payload bytes only when the whole frame is good. Produces per-frame success and error pulses, frame and error counters, and a byte-select preview port for the board display.

---
 rtl/frame_receiver.sv | 204 ++++++++++++++++++++
 tb/tb_frame_receiver.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_receiver.sv
// Receive-side frame parser: hunts for a 13-byte frame in the UART byte stream,
// validates length, function, inverted checksum and tail, and publishes the payload
// only for good frames. Emits success/error pulses, counters and a byte preview.
module frame_receiver #(
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic [2:0]  sel,
    output logic [63:0] data_out,
    output logic [7:0]  preview_data,
    output logic        frame_valid,
    output logic        frame_error,
    output logic [2:0]  err_code,
    output logic [7:0]  frame_count,
    output logic [7:0]  error_count
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT - 1);

    localparam logic [7:0] HDR_BYTE  = 8'h52;
    localparam logic [7:0] LEN_BYTE  = 8'h0C;
    localparam logic [7:0] FUNC_BYTE = 8'h01;
    localparam logic [7:0] TAIL_BYTE = 8'h9A;

    localparam logic [2:0] ERR_LEN   = 3'd1;
    localparam logic [2:0] ERR_FUNC  = 3'd2;
    localparam logic [2:0] ERR_CSUM  = 3'd3;
    localparam logic [2:0] ERR_TAIL  = 3'd4;
    localparam logic [2:0] ERR_TIME  = 3'd5;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StFunc,
        StData,
        StCsum,
        StTail
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      acc_q, acc_d;
    logic [2:0]      idx_q, idx_d;
    logic            csum_ok_q, csum_ok_d;
    logic [CW-1:0]   idle_q, idle_d;
    logic [63:0]     shadow_q;

    logic            shadow_we;
    logic            good;
    logic            fail;
    logic [2:0]      fail_code;

    // Next-state decode: advances only on accepted bytes; any fault returns to idle.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        csum_ok_d = csum_ok_q;
        idle_d    = '0;
        shadow_we = 1'b0;
        good      = 1'b0;
        fail      = 1'b0;
        fail_code = 3'd0;

        if (state_q != StIdle && !rx_valid) begin
            idle_d = idle_q + CW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (rx_valid && rx_data == HDR_BYTE) begin
                    state_d = StLen;
                    acc_d   = HDR_BYTE;
                end
            end
            StLen: begin
                if (rx_valid) begin
                    if (rx_data == LEN_BYTE) begin
                        state_d = StFunc;
                        acc_d   = acc_q + rx_data;
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_LEN;
                    end
                end
            end
            StFunc: begin
                if (rx_valid) begin
                    if (rx_data == FUNC_BYTE) begin
                        state_d = StData;
                        acc_d   = acc_q + rx_data;
                        idx_d   = 3'd0;
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_FUNC;
                    end
                end
            end
            StData: begin
                if (rx_valid) begin
                    shadow_we = 1'b1;
                    acc_d     = acc_q + rx_data;
                    idx_d     = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                // Fold the fixed tail in now so the tail state only has to check the byte.
                if (rx_valid) begin
                    csum_ok_d = (rx_data == ~(acc_q + TAIL_BYTE));
                    state_d   = StTail;
                end
            end
            StTail: begin
                if (rx_valid) begin
                    state_d = StIdle;
                    if (rx_data != TAIL_BYTE) begin
                        fail      = 1'b1;
                        fail_code = ERR_TAIL;
                    end else if (!csum_ok_q) begin
                        fail      = 1'b1;
                        fail_code = ERR_CSUM;
                    end else begin
                        good = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A byte in the expiry cycle wins over the timeout.
        if (state_q != StIdle && !rx_valid && idle_q == IDLE_LAST) begin
            fail      = 1'b1;
            fail_code = ERR_TIME;
        end

        if (fail) begin
            state_d = StIdle;
            idle_d  = '0;
        end
    end

    // Parser state and frame-local bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= 8'h00;
            idx_q     <= 3'd0;
            csum_ok_q <= 1'b0;
            idle_q    <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            csum_ok_q <= csum_ok_d;
            idle_q    <= idle_d;
        end
    end

    // Payload shadow, published payload, pulses, error code and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q    <= 64'h0;
            data_out    <= 64'h0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            err_code    <= 3'd0;
            frame_count <= 8'h00;
            error_count <= 8'h00;
        end else begin
            frame_valid <= good;
            frame_error <= fail;
            if (shadow_we) begin
                // Byte k lives at [63-8k -: 8], i.e. base 8*(7-k).
                shadow_q[{~idx_q, 3'b000} +: 8] <= rx_data;
            end
            if (good) begin
                data_out    <= shadow_q;
                frame_count <= frame_count + 8'h01;
            end
            if (fail) begin
                err_code <= fail_code;
                if (error_count != 8'hFF) begin
                    error_count <= error_count + 8'h01;
                end
            end
        end
    end

    // Display preview: selected byte of the published payload, one cycle behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            preview_data <= 8'h00;
        end else begin
            preview_data <= data_out[{~sel, 3'b000} +: 8];
        end
    end

endmodule

// File: tb/tb_frame_receiver.sv
// Bench for frame_receiver: directed frames from the bring-up plan followed by
// randomized traffic; a byte-level reference model feeds an expected-event queue
// that a negedge monitor drains whenever the DUT pulses.
module tb_frame_receiver;

    localparam int unsigned TIMEOUT = 16;

    typedef logic [7:0] frame_t [13];

    typedef struct {
        bit          good;
        logic [2:0]  code;
        logic [63:0] data;
        logic [7:0]  fc;
        logic [7:0]  ec;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [2:0]  sel;
    logic [63:0] data_out;
    logic [7:0]  preview_data;
    logic        frame_valid;
    logic        frame_error;
    logic [2:0]  err_code;
    logic [7:0]  frame_count;
    logic [7:0]  error_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rand_sel = 1'b0;

    exp_t        expq[$];
    logic [7:0]  mbuf[$];
    int          midle = 0;
    logic [63:0] m_data = '0;
    int          m_fc = 0;
    int          m_ec = 0;
    logic [2:0]  m_code = '0;

    frame_receiver #(
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .sel          (sel),
        .data_out     (data_out),
        .preview_data (preview_data),
        .frame_valid  (frame_valid),
        .frame_error  (frame_error),
        .err_code     (err_code),
        .frame_count  (frame_count),
        .error_count  (error_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // ---------------- reference model (byte-level frame semantics) ----------------
    function automatic void push_event(input bit good, input int c);
        exp_t e;
        e.good = good;
        e.code = m_code;
        e.data = m_data;
        e.fc   = 8'(m_fc);
        e.ec   = 8'(m_ec);
        e.cyc  = c;
        expq.push_back(e);
    endfunction

    function automatic void model_fail(input logic [2:0] code, input int c);
        mbuf.delete();
        midle  = 0;
        m_code = code;
        if (m_ec < 255) m_ec++;
        push_event(1'b0, c);
    endfunction

    function automatic void model_byte(input logic [7:0] b, input int c);
        logic [7:0] sum;
        midle = 0;
        if (mbuf.size() == 0) begin
            if (b == 8'h52) mbuf.push_back(b);
        end else if (mbuf.size() == 1 && b != 8'h0C) begin
            model_fail(3'd1, c);
        end else if (mbuf.size() == 2 && b != 8'h01) begin
            model_fail(3'd2, c);
        end else if (mbuf.size() < 12) begin
            mbuf.push_back(b);
        end else begin
            sum = 8'h9A;
            for (int i = 0; i < 11; i++) sum = sum + mbuf[i];
            if (b != 8'h9A) begin
                model_fail(3'd4, c);
            end else if (mbuf[11] != ~sum) begin
                model_fail(3'd3, c);
            end else begin
                for (int k = 0; k < 8; k++) m_data[63 - 8*k -: 8] = mbuf[3 + k];
                m_fc = (m_fc + 1) % 256;
                mbuf.delete();
                push_event(1'b1, c);
            end
        end
    endfunction

    function automatic void model_idle(input int c);
        if (mbuf.size() > 0) begin
            midle++;
            if (midle == TIMEOUT) model_fail(3'd5, c);
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        if (rand_sel) sel = 3'($urandom);
        model_byte(b, cyc + 1);
    endtask

    task automatic idle_cyc();
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        if (rand_sel) sel = 3'($urandom);
        model_idle(cyc + 1);
    endtask

    task automatic send_bytes(input frame_t f, input int n, input bit gaps);
        int g;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 9);
                if (g >= 9) repeat (TIMEOUT - 1) idle_cyc();
                else if (g >= 6) repeat ($urandom_range(1, 3)) idle_cyc();
            end
            send_byte(f[i]);
        end
    endtask

    task automatic settle();
        idle_cyc();
        @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_data_out"}, data_out, 64'h0);
        check({tag, "_preview"}, {56'h0, preview_data}, 64'h0);
        check({tag, "_valid"}, {63'h0, frame_valid}, 64'h0);
        check({tag, "_error"}, {63'h0, frame_error}, 64'h0);
        check({tag, "_err_code"}, {61'h0, err_code}, 64'h0);
        check({tag, "_frame_count"}, {56'h0, frame_count}, 64'h0);
        check({tag, "_error_count"}, {56'h0, error_count}, 64'h0);
    endtask

    task automatic mid_reset();
        idle_cyc();
        @(negedge clk);
        #1;
        check("queue_empty_at_reset", expq.size(), 0);
        rst = 1'b1;
        mbuf.delete();
        midle  = 0;
        m_data = '0;
        m_fc   = 0;
        m_ec   = 0;
        m_code = '0;
        #1;
        check_zero_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic void build_frame(input logic [63:0] d, output frame_t f);
        logic [7:0] sum;
        f[0] = 8'h52;
        f[1] = 8'h0C;
        f[2] = 8'h01;
        sum  = 8'h52 + 8'h0C + 8'h01 + 8'h9A;
        for (int k = 0; k < 8; k++) begin
            f[3 + k] = d[63 - 8*k -: 8];
            sum      = sum + f[3 + k];
        end
        f[11] = ~sum;
        f[12] = 8'h9A;
    endfunction

    task automatic random_frame();
        frame_t f;
        int     kind;
        build_frame({$urandom, $urandom}, f);
        kind = $urandom_range(0, 9);
        case (kind)
            0: do f[1] = 8'($urandom); while (f[1] == 8'h0C);
            1: do f[2] = 8'($urandom); while (f[2] == 8'h01);
            2: f[11] = f[11] ^ 8'($urandom_range(1, 255));
            3: do f[12] = 8'($urandom); while (f[12] == 8'h9A);
            default: ;
        endcase
        if (kind == 4) begin
            repeat ($urandom_range(1, 5)) send_byte(8'($urandom));
        end else if (kind == 5) begin
            send_bytes(f, $urandom_range(1, 12), 1'b1);
            repeat (TIMEOUT + $urandom_range(0, 3)) idle_cyc();
        end else if (kind == 6 && $urandom_range(0, 2) == 0) begin
            send_bytes(f, $urandom_range(1, 12), 1'b0);
            mid_reset();
        end else begin
            send_bytes(f, 13, 1'b1);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [63:0] mon_data  = '0;
    logic [63:0] prev_data = '0;
    logic [2:0]  prev_sel  = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            mon_data  = '0;
            prev_data = '0;
            prev_sel  = '0;
        end else begin
            check("preview_data", {56'h0, preview_data}, {56'h0, prev_data[63 - 8*prev_sel -: 8]});
            if (frame_valid || frame_error) begin
                if (expq.size() == 0) begin
                    check("unexpected_pulse", {62'h0, frame_valid, frame_error}, 64'h0);
                end else begin
                    e = expq.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("frame_valid", {63'h0, frame_valid}, {63'h0, e.good});
                    check("frame_error", {63'h0, frame_error}, {63'h0, !e.good});
                    check("err_code", {61'h0, err_code}, {61'h0, e.code});
                    check("frame_count", {56'h0, frame_count}, {56'h0, e.fc});
                    check("error_count", {56'h0, error_count}, {56'h0, e.ec});
                    mon_data = e.data;
                end
            end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
                e = expq.pop_front();
                check("pulse_present", {63'h0, frame_valid | frame_error}, 64'h1);
                mon_data = e.data;
            end
            check("data_out", data_out, mon_data);
            prev_data = mon_data;
            prev_sel  = sel;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        frame_t fr1;
        frame_t fr0;
        fr1 = '{8'h52, 8'h0C, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                8'h08, 8'hE2, 8'h9A};
        fr0 = '{8'h52, 8'h0C, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h06, 8'h9A};

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        sel      = 3'd2;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;

        // Good frame, then preview of byte 2.
        send_bytes(fr1, 13, 1'b0);
        settle();
        check("d1_data", data_out, 64'h0102030405060708);
        check("d1_count", {56'h0, frame_count}, 64'd1);
        settle();
        check("d1_preview", {56'h0, preview_data}, 64'h03);

        // Leading garbage, then all-zero payload.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_bytes(fr0, 13, 1'b0);
        settle();
        check("d2_data", data_out, 64'h0);
        check("d2_errors", {56'h0, error_count}, 64'd0);
        check("d2_count", {56'h0, frame_count}, 64'd2);

        // Bad checksum.
        fr1[11] = 8'hE3;
        send_bytes(fr1, 13, 1'b0);
        fr1[11] = 8'hE2;
        settle();
        check("d3_err_code", {61'h0, err_code}, 64'd3);
        check("d3_errors", {56'h0, error_count}, 64'd1);
        check("d3_data_kept", data_out, 64'h0);

        // Bad length, then a good frame.
        send_byte(8'h52);
        send_byte(8'h0D);
        settle();
        check("d4_err_code", {61'h0, err_code}, 64'd1);
        send_bytes(fr1, 13, 1'b0);
        settle();
        check("d4_count", {56'h0, frame_count}, 64'd3);

        // Timeout after 16 idle cycles.
        send_byte(8'h52);
        send_byte(8'h0C);
        repeat (TIMEOUT) idle_cyc();
        settle();
        check("d5_err_code", {61'h0, err_code}, 64'd5);
        check("d5_errors", {56'h0, error_count}, 64'd3);

        // Byte arriving on the 16th idle cycle keeps the frame alive.
        send_byte(8'h52);
        send_byte(8'h0C);
        repeat (TIMEOUT - 1) idle_cyc();
        for (int i = 2; i < 13; i++) send_byte(fr1[i]);
        settle();
        check("d6_errors", {56'h0, error_count}, 64'd3);
        check("d6_count", {56'h0, frame_count}, 64'd4);

        // Reset mid-frame, then a full good frame.
        send_bytes(fr1, 6, 1'b0);
        mid_reset();
        send_bytes(fr1, 13, 1'b0);
        settle();
        check("d7_count", {56'h0, frame_count}, 64'd1);
        check("d7_data", data_out, 64'h0102030405060708);

        // Randomized traffic.
        rand_sel = 1'b1;
        repeat (400) random_frame();

        repeat (TIMEOUT + 4) idle_cyc();
        @(negedge clk);
        #1;
        check("queue_drained", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
